// File: rtl/data_ram_responder.sv
// data_ram_responder
//
// Byte-serial data memory that services the MEM-stage control bundle.
// A request is accepted in IDLE. The FSM then moves one byte per clock
// through ACCESS and pulses Done for one cycle in DONE. Items are
// big-endian: the byte at the start address is the most significant
// byte of the item. Addresses wrap modulo DEPTH.
//
// Parameters:
//   ADDR_W      byte-address width
//   DEPTH       number of bytes in Mem[0:DEPTH-1]
//
// Ports:
//   clk         clock, rising-edge active
//   Reset       synchronous active-high reset (Mem is not cleared)
//   RAM_Enable  access request
//   RAM_RW      1 = write, 0 = read
//   RAM_SE      sign-extend halfword/byte reads
//   RAM_Size    00 byte, 01 halfword, 10/11 word
//   A           start byte address
//   DI          right-justified write data
//   DO          read data extended to 32 bits, updated by reads only
//   Busy        stall request to the pipeline
//   Done        one-cycle completion pulse
//   Misaligned  (only with DATA_RAM_ALIGN_CHECK_EN) flags a rejected
//               misaligned halfword/word, high together with Done
//
// Optional feature macro: DATA_RAM_ALIGN_CHECK_EN
module data_ram_responder #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              RAM_Enable,
  input  logic              RAM_RW,
  input  logic              RAM_SE,
  input  logic [1:0]        RAM_Size,
  input  logic [ADDR_W-1:0] A,
  input  logic [31:0]       DI,
  output logic [31:0]       DO,
  output logic              Busy,
  output logic              Done
`ifdef DATA_RAM_ALIGN_CHECK_EN
  ,
  output logic              Misaligned
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, next_state;
  logic [1:0]        k;
  logic [1:0]        last_k;
  logic              rw_lat;
  logic              se_lat;
  logic [1:0]        size_lat;
  logic [ADDR_W-1:0] addr_lat;
  logic [31:0]       wr_sh;
  logic [23:0]       rd_acc;
  logic [ADDR_W:0]   addr_sum;
  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        cur_byte;
  logic [31:0]       rd_item;
  logic              req_mis;

  logic [7:0] Mem [0:DEPTH-1];

`ifdef DATA_RAM_ALIGN_CHECK_EN
  logic mis_lat;
  assign req_mis    = ((RAM_Size == 2'b01) && A[0]) ||
                      (RAM_Size[1] && (A[1:0] != 2'b00));
  assign Misaligned = (state == DONE) && mis_lat;
`else
  assign req_mis = 1'b0;
`endif

  // Index of the final byte of the latched item: 0, 1 or 3.
  always_comb begin
    case (size_lat)
      2'b00:   last_k = 2'd0;
      2'b01:   last_k = 2'd1;
      default: last_k = 2'd3;
    endcase
  end

  // Current byte address. The sum is one bit wider so that a DEPTH
  // that is not a power of two still wraps correctly.
  always_comb begin
    addr_sum = {1'b0, addr_lat} + (ADDR_W+1)'(k);
    if (addr_sum >= (ADDR_W+1)'(DEPTH))
      addr_sum = addr_sum - (ADDR_W+1)'(DEPTH);
    cur_addr = addr_sum[ADDR_W-1:0];
  end

  assign cur_byte = Mem[cur_addr];

  // Complete read item: earlier bytes come from the accumulator and the
  // final byte is read directly from the array. Sub-word items are then
  // extended according to the latched SE flag.
  always_comb begin
    case (size_lat)
      2'b00:   rd_item = se_lat ? {{24{cur_byte[7]}}, cur_byte}
                                : {24'h000000, cur_byte};
      2'b01:   rd_item = se_lat ? {{16{rd_acc[7]}}, rd_acc[7:0], cur_byte}
                                : {16'h0000, rd_acc[7:0], cur_byte};
      default: rd_item = {rd_acc, cur_byte};
    endcase
  end

  // Next-state and handshake outputs. Busy in IDLE follows the request
  // combinationally so the pipeline stalls in the request cycle itself.
  always_comb begin
    next_state = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: begin
        Busy = RAM_Enable;
        if (RAM_Enable)
          next_state = req_mis ? DONE : ACCESS;
      end
      ACCESS: begin
        Busy = 1'b1;
        if (k == last_k)
          next_state = DONE;
      end
      DONE: begin
        Done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Control state. Write data is left-aligned at accept time so that the
  // byte to store is always wr_sh[31:24], and reads shift bytes in from
  // the right as they arrive.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= IDLE;
      k     <= 2'd0;
      DO    <= 32'h0;
`ifdef DATA_RAM_ALIGN_CHECK_EN
      mis_lat <= 1'b0;
`endif
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (RAM_Enable) begin
            rw_lat   <= RAM_RW;
            se_lat   <= RAM_SE;
            size_lat <= RAM_Size;
            addr_lat <= A;
            rd_acc   <= 24'h000000;
            k        <= 2'd0;
            case (RAM_Size)
              2'b00:   wr_sh <= {DI[7:0], 24'h000000};
              2'b01:   wr_sh <= {DI[15:0], 16'h0000};
              default: wr_sh <= DI;
            endcase
`ifdef DATA_RAM_ALIGN_CHECK_EN
            mis_lat <= req_mis;
`endif
          end
        end
        ACCESS: begin
          k      <= k + 2'd1;
          wr_sh  <= {wr_sh[23:0], 8'h00};
          rd_acc <= {rd_acc[15:0], cur_byte};
          if ((k == last_k) && !rw_lat)
            DO <= rd_item;
        end
        default: ;
      endcase
    end
  end

  // Byte array. Reset leaves the contents alone but blocks any further
  // stores from an interrupted write.
  always_ff @(posedge clk) begin
    if (!Reset && (state == ACCESS) && rw_lat)
      Mem[cur_addr] <= wr_sh[31:24];
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// tb_data_ram_responder
//
// Self-checking bench for data_ram_responder. The bench keeps a byte-array
// model of memory and derives, for every transaction, the cycle-by-cycle
// Busy/Done timeline (Busy high for request + N cycles, then Done) and the
// resulting read value. A negedge compare process checks the outputs against
// these expectations. Literal checks pin the model to hand-computed values.
// Works with or without DATA_RAM_ALIGN_CHECK_EN.
module tb_data_ram_responder;

  logic        clk;
  logic        Reset;
  logic        RAM_Enable;
  logic        RAM_RW;
  logic        RAM_SE;
  logic [1:0]  RAM_Size;
  logic [8:0]  A;
  logic [31:0] DI;
  logic [31:0] DO;
  logic        Busy;
  logic        Done;
`ifdef DATA_RAM_ALIGN_CHECK_EN
  logic        Misaligned;
`endif

  logic        check_en;
  logic        exp_busy;
  logic        exp_done;
  logic        exp_mis;
  logic [31:0] exp_do;
  logic [7:0]  model_mem [0:511];
  int          tests;
  int          fails;
  int          done_count;
  int          done_base;

  data_ram_responder #(.ADDR_W(9), .DEPTH(512)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .RAM_Enable (RAM_Enable),
    .RAM_RW     (RAM_RW),
    .RAM_SE     (RAM_SE),
    .RAM_Size   (RAM_Size),
    .A          (A),
    .DI         (DI),
    .DO         (DO),
    .Busy       (Busy),
    .Done       (Done)
`ifdef DATA_RAM_ALIGN_CHECK_EN
    ,
    .Misaligned (Misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a failing one.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference read: concatenate bytes big-endian, then extend.
  function automatic logic [31:0] modelRead(input int a, input int n,
                                            input logic se);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < n; i++)
      v = (v << 8) | {24'h0, model_mem[(a + i) % 512]};
    if (n < 4 && se && v[8*n-1])
      v = v | ~((32'h1 << (8*n)) - 32'h1);
    return v;
  endfunction

  // Mid-cycle compare of every output against the bench expectations.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput($sformatf("busy@%0t", $time), {31'b0, Busy}, {31'b0, exp_busy});
      checkOutput($sformatf("done@%0t", $time), {31'b0, Done}, {31'b0, exp_done});
      checkOutput($sformatf("do@%0t", $time), DO, exp_do);
`ifdef DATA_RAM_ALIGN_CHECK_EN
      checkOutput($sformatf("mis@%0t", $time), {31'b0, Misaligned}, {31'b0, exp_mis});
`endif
      if (Done === 1'b1)
        done_count++;
    end
  end

  // One transaction. hold keeps RAM_Enable high throughout and skips the
  // trailing idle cycle so the next call is accepted right after DONE.
  task automatic applyStimulus(input logic rw, input logic se,
                               input logic [1:0] size, input int a,
                               input logic [31:0] di, input bit hold);
    int          n;
    int          lim;
    logic        mis;
    logic [31:0] tmp;
    n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    mis = 1'b0;
`ifdef DATA_RAM_ALIGN_CHECK_EN
    mis = ((n == 2) && (a % 2 != 0)) || ((n == 4) && (a % 4 != 0));
`endif
    lim = mis ? 0 : n;
    @(posedge clk); #1;
    RAM_Enable = 1'b1;
    RAM_RW     = rw;
    RAM_SE     = se;
    RAM_Size   = size;
    A          = 9'(a);
    DI         = di;
    exp_busy   = 1'b1;
    exp_done   = 1'b0;
    exp_mis    = 1'b0;
    for (int c = 1; c <= lim; c++) begin
      @(posedge clk); #1;
      if (!hold) RAM_Enable = 1'b0;
      A  = ~A;
      DI = ~DI;
      exp_busy = 1'b1;
    end
    @(posedge clk); #1;
    if (!hold) RAM_Enable = 1'b0;
    exp_busy = 1'b0;
    exp_done = 1'b1;
    exp_mis  = mis;
    if (!mis) begin
      if (rw) begin
        for (int i = 0; i < n; i++) begin
          tmp = di >> (8 * (n - 1 - i));
          model_mem[(a + i) % 512] = tmp[7:0];
        end
      end else begin
        exp_do = modelRead(a, n, se);
      end
    end
    if (!hold) begin
      @(posedge clk); #1;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_mis  = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tests      = 0;
    fails      = 0;
    done_count = 0;
    done_base  = 0;
    check_en   = 1'b0;
    exp_busy   = 1'b0;
    exp_done   = 1'b0;
    exp_mis    = 1'b0;
    exp_do     = 32'h0;
    Reset      = 1'b1;
    RAM_Enable = 1'b0;
    RAM_RW     = 1'b0;
    RAM_SE     = 1'b0;
    RAM_Size   = 2'b00;
    A          = 9'h0;
    DI         = 32'h0;

    for (int i = 0; i < 512; i++) begin
      model_mem[i] = 8'(i * 7 + 3);
      dut.Mem[i]   = model_mem[i];
    end
    model_mem[0] = 8'h85; model_mem[1] = 8'hA0;
    model_mem[2] = 8'h12; model_mem[3] = 8'h34;
    for (int i = 0; i < 4; i++) dut.Mem[i] = model_mem[i];

    repeat (2) @(posedge clk);
    #1;
    Reset    = 1'b0;
    check_en = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_do", DO, 32'h0);
    checkOutput("reset_busy", {31'b0, Busy}, 32'h0);

    // Word read: Busy cycles 0..4, Done in cycle 5.
    applyStimulus(1'b0, 1'b0, 2'b10, 0, 32'h0, 1'b0);
    checkOutput("lit_word_read", DO, 32'h85A01234);
    applyStimulus(1'b0, 1'b1, 2'b01, 0, 32'h0, 1'b0);
    checkOutput("lit_half_se", DO, 32'hFFFF85A0);
    applyStimulus(1'b0, 1'b0, 2'b01, 0, 32'h0, 1'b0);
    checkOutput("lit_half_ze", DO, 32'h000085A0);
    applyStimulus(1'b0, 1'b1, 2'b00, 2, 32'h0, 1'b0);
    checkOutput("lit_byte_se_pos", DO, 32'h00000012);

    // Word write leaves DO alone.
    applyStimulus(1'b1, 1'b0, 2'b10, 8, 32'hDEADBEEF, 1'b0);
    checkOutput("lit_wr_do_hold", DO, 32'h00000012);
    checkOutput("lit_mem8", {24'h0, dut.Mem[8]}, 32'hDE);
    checkOutput("lit_mem9", {24'h0, dut.Mem[9]}, 32'hAD);
    checkOutput("lit_mem10", {24'h0, dut.Mem[10]}, 32'hBE);
    checkOutput("lit_mem11", {24'h0, dut.Mem[11]}, 32'hEF);
    applyStimulus(1'b0, 1'b1, 2'b00, 9, 32'h0, 1'b0);
    checkOutput("lit_byte_se_neg", DO, 32'hFFFFFFAD);

    // Halfword across the top of the array.
    applyStimulus(1'b1, 1'b0, 2'b01, 511, 32'h0000ABCD, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b01, 511, 32'h0, 1'b0);
`ifndef DATA_RAM_ALIGN_CHECK_EN
    checkOutput("lit_mem511", {24'h0, dut.Mem[511]}, 32'hAB);
    checkOutput("lit_mem0", {24'h0, dut.Mem[0]}, 32'hCD);
    checkOutput("lit_wrap_read", DO, 32'h0000ABCD);
`endif

    // Reset on the edge after the first byte of a word write.
    @(posedge clk); #1;
    RAM_Enable = 1'b1; RAM_RW = 1'b1; RAM_SE = 1'b0; RAM_Size = 2'b10;
    A = 9'd16; DI = 32'h11223344;
    exp_busy = 1'b1; exp_done = 1'b0;
    @(posedge clk); #1;
    RAM_Enable = 1'b0;
    @(posedge clk); #1;
    Reset = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0;
    exp_busy = 1'b0; exp_done = 1'b0; exp_do = 32'h0;
    model_mem[16] = 8'h11;
    @(posedge clk); #1;
    checkOutput("lit_rst_do", DO, 32'h0);
    checkOutput("lit_rst_mem16", {24'h0, dut.Mem[16]}, 32'h11);
    checkOutput("lit_rst_mem17", {24'h0, dut.Mem[17]}, 32'h7A);
    checkOutput("lit_rst_mem18", {24'h0, dut.Mem[18]}, 32'h81);
    checkOutput("lit_rst_mem19", {24'h0, dut.Mem[19]}, 32'h88);

    // Three back-to-back word reads with RAM_Enable held high.
    done_base = done_count;
    applyStimulus(1'b0, 1'b0, 2'b10, 0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'b10, 4, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'b10, 8, 32'h0, 1'b0);
    checkOutput("lit_b2b_done_count", 32'(done_count - done_base), 32'd3);
    checkOutput("lit_b2b_last", DO, 32'hDEADBEEF);

`ifdef DATA_RAM_ALIGN_CHECK_EN
    applyStimulus(1'b0, 1'b0, 2'b10, 2, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b10, 2, 32'hCAFEF00D, 1'b0);
    checkOutput("lit_mis_mem2", {24'h0, dut.Mem[2]}, 32'h12);
    checkOutput("lit_mis_do", DO, 32'hDEADBEEF);
`else
    applyStimulus(1'b0, 1'b0, 2'b10, 3, 32'h0, 1'b0);
    checkOutput("lit_misaligned_word", DO, 32'h341F262D);
`endif

    check_en = 1'b0;
    for (int i = 0; i < 512; i++)
      checkOutput($sformatf("mem[%0d]", i), {24'h0, dut.Mem[i]}, {24'h0, model_mem[i]});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
